serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial bit-pattern transmitter. It loads a WIDTH-bit word and shifts it out MSB first, one bit per DIV clocks, and can repeat the word a programmable number of times. It is the stimulus side of the lab's Moore sequence detectors: its `out` drives a detector's single-bit `in`, so on-board patterns can be sent without hand-toggled switches.

## Interface
- `WIDTH`, 8: pattern length in bits; must be ≥ 2.
- `CNT_W`, 4: width of the repeat count.
- `DIV`, 1: clocks per transmitted bit; must be ≥ 1.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `data`  in  WIDTH  pattern to send; captured when start is accepted.
- `repeat_n`  in  CNT_W  extra repetitions (0 = send once, 2^CNT_W−1 = max); captured when start is accepted.
- `busy`  out  1  high while in SHIFT.
- `out`  out  1  serial bit stream.
- `out_valid`  out  1  high while `out` carries a pattern bit.
- `done`  out  1  single-cycle pulse after the last bit.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SHIFT: bits are being sent.
  - DONE: one-cycle completion state.
- Reset (synchronous): next edge gives state=IDLE, and `out`=0, `out_valid`=0, `busy`=0, `done`=0. All counters and the shift register clear to 0.
- IDLE with `start`=1: capture `data` into the shift register and `repeat_n` into the repeat counter. Clear the bit counter and the divider. Go to SHIFT.
- IDLE with `start`=0: stay in IDLE. Outputs hold their reset values.
- SHIFT behaviour:
  - `out` = shift_reg[WIDTH-1], `out_valid`=1, `busy`=1.
  - The divider counts 0..DIV-1. When the divider reaches DIV-1, the current bit period ends: the register rotates left by 1 and the bit counter increments.
  - Rotation, not shift, keeps the pattern intact for repeats.
- End of a word: the bit period of bit index WIDTH-1 ends.
  - If the repeat counter is non-zero: decrement it, clear the bit counter, stay in SHIFT. The word restarts with no gap.
  - If the repeat counter is zero: go to DONE.
- DONE: `done`=1, `out`=0, `out_valid`=0, `busy`=0. Unconditionally go to IDLE next cycle.
- `start` is ignored in SHIFT and DONE. It is not queued; a new word needs `start` high while in IDLE.
- `data` and `repeat_n` changes after capture have no effect on the word in flight.
- The state encoding's unused code goes to IDLE on the next edge with outputs deasserted.
- Counter widths:
  - bit counter: $clog2(WIDTH)
  - divider: $clog2(DIV), minimum 1 bit
  - repeat counter: CNT_W
- No counter may wrap during valid operation.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Start latency: `start` sampled high in IDLE at edge k gives the first bit on `out` with `out_valid`=1 during cycle k+1.
- Each bit is held exactly DIV cycles.
- SHIFT lasts exactly (repeat_n+1)·WIDTH·DIV cycles.
- `done` is high for exactly 1 cycle, immediately after the last SHIFT cycle.
- The earliest re-accept of `start` is the edge after DONE, i.e. IDLE. Minimum start-to-start period is (repeat_n+1)·WIDTH·DIV + 2 cycles.
- Reset mid-SHIFT takes effect at the next edge:
  - `out_valid`, `busy` and `out` drop to 0.
  - No `done` pulse is produced.
  - The word is abandoned.
- Reset has priority over `start` on the same edge.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `start`=1 → `out`, `out_valid`, `busy` and `done` are all 0; state stays IDLE for one cycle after `rst` falls if `start`=0.
- Single word, DIV=1, WIDTH=8: `data`=8'hB0, `repeat_n`=0, one-cycle `start` → `out` = 1,0,1,1,0,0,0,0 on 8 consecutive cycles starting 1 cycle after `start`; `done` high on the 9th cycle; `busy` high for exactly 8 cycles.
- Repeat with no gap: `data`=8'h0B, `repeat_n`=2 → 24 contiguous valid bits, 0000_1011 three times; one `done` pulse only, after bit 24.
- Divider, DIV=3 build: `data`=8'hA5 → each bit is held 3 cycles; SHIFT lasts 24 cycles; the bit sequence is 1,0,1,0,0,1,0,1.
- Ignored inputs:
  - Pulse `start` and change `data` to 8'hFF mid-word → the transmitted word is unchanged and no second word follows.
  - `start` held high continuously → back-to-back words separated by exactly the DONE and IDLE cycles (2-cycle gap).
- Reset mid-operation: assert `rst` after bit 3 of 8'hB0 → `out_valid`=0 on the next edge, no `done` pulse; a fresh `start` then sends the full 8 bits from the MSB.

Source files
------------

// File: rtl/serial_pattern_tx_if.sv
// Handshake/bus bundle for serial_pattern_tx: request side (start/data/repeat_n)
// and transmit side (busy/out/out_valid/done), plus the FSM state for checkers.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    // Handshake: start is a level request honoured only while the transmitter is
    // idle; data/repeat_n are captured on that same edge. out_valid marks every
    // cycle that out carries a pattern bit, and done pulses once per finished job.
    logic             start;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] repeat_n;
    logic             busy;
    logic             out;
    logic             out_valid;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, data, repeat_n,
        input  busy, out, out_valid, done, state_dbg
    );

    modport slave (
        input  start, data, repeat_n,
        output busy, out, out_valid, done, state_dbg
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a WIDTH-bit word MSB first, DIV clocks
// per bit, optionally repeating it back to back, with fully registered outputs.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int DIV   = 1
) (
    input logic               clk,
    input logic               rst,
    serial_pattern_tx_if.slave tx
);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] rotated;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             out_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    // Rotating keeps the whole word in place so repeats need no reload.
    assign rotated = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            rep_cnt   <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (tx.start) begin
                        state     <= S_SHIFT;
                        shift_reg <= tx.data;
                        rep_cnt   <= tx.repeat_n;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        out_q     <= tx.data[WIDTH-1];
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        out_q   <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    // out is registered, so it is loaded with the bit that the
                    // register will present after this edge's rotation.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        shift_reg <= rotated;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (rep_cnt != '0) begin
                                rep_cnt <= rep_cnt - 1'b1;
                                out_q   <= rotated[WIDTH-1];
                            end else begin
                                state   <= S_DONE;
                                out_q   <= 1'b0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            out_q   <= rotated[WIDTH-1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    out_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    // Unused encoding recovers to IDLE with everything quiet.
                    state   <= S_IDLE;
                    out_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.out       = out_q;
    assign tx.out_valid = valid_q;
    assign tx.busy      = busy_q;
    assign tx.done      = done_q;
    assign tx.state_dbg = state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomised scoreboard bench for serial_pattern_tx, with a DIV=1 and a DIV=3
// instance; expected per-cycle output tuples are queued when a word is requested.
module tb_serial_pattern_tx;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus1 ();
    serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus3 ();

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV(1)) dut (
        .clk(clk), .rst(rst), .tx(bus1.slave)
    );
    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .tx(bus3.slave)
    );

    // ---------------- scoreboard ----------------
    // Tuple layout: {busy, out_valid, out, done}
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q1[$];
    logic [3:0] exp_q3[$];
    bit         in_word1 = 1'b0;
    bit         in_word3 = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // Reference: a word is (rep+1) copies of its bits MSB first, each bit held
    // div cycles, followed by a single done cycle with everything else low.
    task automatic push_word(ref logic [3:0] q[$], input logic [WIDTH-1:0] d,
                             input int rep, input int div);
        for (int r = 0; r <= rep; r++)
            for (int i = WIDTH - 1; i >= 0; i--)
                for (int k = 0; k < div; k++)
                    q.push_back({1'b1, 1'b1, d[i], 1'b0});
        q.push_back(4'b0001);
    endtask

    task automatic mon_step(ref logic [3:0] q[$], ref bit in_word,
                            input logic [3:0] got, input string name);
        if (rst) begin
            in_word = 1'b0;
            return;
        end
        if (got[2] || got[0]) begin
            if (q.size() == 0) check({name, "_unexpected"}, got, 4'h0);
            else               check({name, "_stream"}, got, q.pop_front());
            in_word = got[2];
        end else if (in_word) begin
            check({name, "_gap"}, got[2], 1'b1);
            in_word = 1'b0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_step(exp_q1, in_word1, {bus1.busy, bus1.out_valid, bus1.out, bus1.done}, "div1");
    end

    initial forever begin
        @(negedge clk);
        mon_step(exp_q3, in_word3, {bus3.busy, bus3.out_valid, bus3.out, bus3.done}, "div3");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_word(input int sel, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] rep);
        if (sel == 1) begin
            bus1.data = d; bus1.repeat_n = rep; bus1.start = 1'b1;
            push_word(exp_q1, d, int'(rep), 1);
        end else begin
            bus3.data = d; bus3.repeat_n = rep; bus3.start = 1'b1;
            push_word(exp_q3, d, int'(rep), 3);
        end
        tick();
        if (sel == 1) begin
            bus1.start = 1'b0;
            check("latency_valid1", bus1.out_valid, 1'b1);
            check("latency_msb1", bus1.out, d[WIDTH-1]);
        end else begin
            bus3.start = 1'b0;
            check("latency_valid3", bus3.out_valid, 1'b1);
            check("latency_msb3", bus3.out, d[WIDTH-1]);
        end
    endtask

    task automatic wait_done(input int sel, input int budget);
        int n = 0;
        while (n < budget && !((sel == 1) ? bus1.done : bus3.done)) begin
            tick();
            n++;
        end
        check("done_seen", (sel == 1) ? bus1.done : bus3.done, 1'b1);
    endtask

    task automatic send_word(input int sel, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] rep);
        begin_word(sel, d, rep);
        wait_done(sel, (int'(rep) + 1) * WIDTH * 3 + 10);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus1.start = 1'b1; bus1.data = 8'hFF; bus1.repeat_n = '0;
        bus3.start = 1'b1; bus3.data = 8'hFF; bus3.repeat_n = '0;
        rst = 1'b1;

        // Reset held 3 cycles with start high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs1", {bus1.busy, bus1.out_valid, bus1.out, bus1.done}, 4'h0);
            check("reset_outputs3", {bus3.busy, bus3.out_valid, bus3.out, bus3.done}, 4'h0);
            check("reset_state", bus1.state_dbg, 2'b00);
        end
        rst = 1'b0; bus1.start = 1'b0; bus3.start = 1'b0;
        tick();
        check("post_reset_idle", bus1.state_dbg, 2'b00);
        check("post_reset_outputs", {bus1.busy, bus1.out_valid, bus1.out, bus1.done}, 4'h0);

        // Single word and repeated word on the DIV=1 build
        send_word(1, 8'hB0, 4'd0);
        send_word(1, 8'h0B, 4'd2);
        check("q1_drained", exp_q1.size(), 0);

        // DIV=3 build
        send_word(3, 8'hA5, 4'd0);
        check("q3_drained", exp_q3.size(), 0);

        // start pulse and data change mid-word are ignored
        begin_word(1, 8'h3C, 4'd0);
        repeat (3) tick();
        bus1.data = 8'hFF; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        wait_done(1, 40);
        repeat (5) tick();
        check("ignored_start_idle", bus1.busy, 1'b0);
        check("ignored_q_empty", exp_q1.size(), 0);

        // start held high: back-to-back words with DONE + IDLE between them
        bus1.data = 8'h5A; bus1.repeat_n = 4'd0; bus1.start = 1'b1;
        push_word(exp_q1, 8'h5A, 0, 1);
        push_word(exp_q1, 8'h5A, 0, 1);
        tick();
        wait_done(1, 40);
        tick();
        check("held_gap_idle", {bus1.busy, bus1.out_valid}, 2'b00);
        check("held_gap_state", bus1.state_dbg, 2'b00);
        tick();
        check("held_restart", {bus1.busy, bus1.out_valid}, 2'b11);
        bus1.start = 1'b0;
        wait_done(1, 40);
        repeat (4) tick();
        check("held_q_empty", exp_q1.size(), 0);

        // Reset during bit 3 of 8'hB0, then a clean resend
        begin_word(1, 8'hB0, 4'd0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        exp_q1.delete();
        rst = 1'b0;
        check("midreset_outputs", {bus1.busy, bus1.out_valid, bus1.out, bus1.done}, 4'h0);
        repeat (3) tick();
        check("midreset_no_done", {bus1.busy, bus1.done}, 2'b00);
        send_word(1, 8'hB0, 4'd0);

        // Randomised words on both builds
        for (int n = 0; n < 12; n++) begin
            send_word(1, WIDTH'($urandom_range(0, 255)), CNT_W'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) tick();
        end
        for (int n = 0; n < 4; n++) begin
            send_word(3, WIDTH'($urandom_range(0, 255)), CNT_W'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        // Max repeat count on the DIV=1 build
        send_word(1, WIDTH'($urandom_range(0, 255)), 4'd15);

        repeat (4) tick();
        check("final_q1_empty", exp_q1.size(), 0);
        check("final_q3_empty", exp_q3.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog timeout got=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
